// File: rtl/chain_seq_pkg.sv
// Shared types and helpers for the XOR/NOT chain vector sequencer.
// Holds the FSM state enum, LFSR constants and the chain golden model.
package chain_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } seq_state_t;

  localparam int LFSR_W = 16;

  // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Pair j: a toggles every stage, b absorbs a at every stage
  function automatic logic [LFSR_W-1:0] chain_golden(
    input logic [LFSR_W-1:0] v,
    input int                io_pairs,
    input int                depth
  );
    logic [LFSR_W-1:0] o;
    logic              a;
    logic              b;
    int                ones;
    o = '0;
    for (int j = 0; j < LFSR_W / 2; j++) begin
      if (j < io_pairs) begin
        a      = v[2*j];
        b      = v[2*j+1];
        ones   = a ? (depth + 1) / 2 : depth / 2;
        o[2*j]   = a ^ depth[0];
        o[2*j+1] = b ^ ones[0];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/chain_seq_lfsr.sv
// 16-bit Fibonacci LFSR, shift-left with feedback into bit 0.
// Load has priority over step; reset value is the effective seed.
module chain_seq_lfsr
  import chain_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= i_seed;
    end else if (i_step) begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/chain_vector_sequencer.sv
// Stimulus/check controller for the XOR/NOT primitive chain benchmark.
// Define CHAIN_SEQ_FIRST_FAIL_EN to add first-mismatch capture outputs.
module chain_vector_sequencer
  import chain_seq_pkg::*;
#(
  parameter int                IO_PAIRS  = 2,
  parameter int                DEPTH     = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           n_vectors,
  input  logic [7:0]            settle_cycles,
  output logic [2*IO_PAIRS-1:0] chain_in,
  input  logic [2*IO_PAIRS-1:0] chain_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
  output logic                  fail_valid,
  output logic [15:0]           fail_idx,
  output logic [2*IO_PAIRS-1:0] fail_data,
`endif
  output logic [15:0]           err_count
);

  localparam int W = 2 * IO_PAIRS;

  localparam logic [LFSR_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;

  seq_state_t r_state;
  seq_state_t w_next;

  logic [15:0]       r_n;
  logic [7:0]        r_settle;
  logic [7:0]        r_cnt;
  logic [15:0]       r_vec_idx;
  logic [W-1:0]      r_exp;
  logic [W-1:0]      r_chain_in;
  logic              r_pass;
  logic [15:0]       r_err;
  logic [15:0]       w_err_next;
  logic              w_mismatch;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [LFSR_W-1:0] w_lfsr;
  logic [LFSR_W-1:0] w_gold;

  chain_seq_lfsr #(
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_seed (SEED_EFF),
    .o_q    (w_lfsr)
  );

  assign w_gold = chain_golden(w_lfsr, IO_PAIRS, DEPTH);

  if (W < LFSR_W) begin : g_unused
    logic w_unused;
    assign w_unused = ^{w_lfsr[LFSR_W-1:W], w_gold[LFSR_W-1:W]};
  end

  assign w_last     = (r_vec_idx == r_n - 16'd1);
  assign w_mismatch = (r_state == CHECK) && (chain_out != r_exp);
  assign w_err_next = (w_mismatch && r_err != 16'hFFFF)
                    ? r_err + 16'd1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = (n_vectors == 16'd0) ? DONE : APPLY;
        end
      end
      APPLY: begin
        w_step = 1'b1;
        w_next = (r_settle == 8'd0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (r_cnt == 8'd1) w_next = CHECK;
      end
      CHECK: begin
        w_next = w_last ? DONE : APPLY;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_settle   <= '0;
      r_cnt      <= '0;
      r_vec_idx  <= '0;
      r_exp      <= '0;
      r_chain_in <= '0;
      r_pass     <= 1'b0;
      r_err      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_n       <= n_vectors;
            r_settle  <= settle_cycles;
            r_vec_idx <= '0;
            r_err     <= '0;
            // An empty run finishes clean
            r_pass    <= (n_vectors == 16'd0);
          end
        end
        APPLY: begin
          r_chain_in <= w_lfsr[W-1:0];
          r_exp      <= w_gold[W-1:0];
          r_cnt      <= r_settle;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 8'd1;
        end
        CHECK: begin
          r_err <= w_err_next;
          if (w_last) begin
            r_pass <= (w_err_next == 16'd0);
          end else begin
            r_vec_idx <= r_vec_idx + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CHAIN_SEQ_FIRST_FAIL_EN
  logic         r_fail_valid;
  logic [15:0]  r_fail_idx;
  logic [W-1:0] r_fail_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_data  <= '0;
    end else if (r_state == IDLE && start) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_data  <= '0;
    end else if (w_mismatch && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_idx   <= r_vec_idx;
      r_fail_data  <= chain_out;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;
  assign fail_data  = r_fail_data;
`endif

  assign chain_in  = r_chain_in;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign err_count = r_err;

endmodule

// File: tb/tb_chain_vector_sequencer.sv
// Directed bench for chain_vector_sequencer with DEPTH=32 and DEPTH=3 instances.
// Chains are modelled stage by stage; expected values are hand-computed.
module tb_chain_vector_sequencer;

  logic        clk;
  logic        rst_n;
  logic        st;
  logic        sel;
  logic [15:0] n_vec;
  logic [7:0]  settle;

  logic        start32, start3;
  logic [3:0]  cin32, cin3;
  logic [3:0]  out32, out3;
  logic        busy32, busy3;
  logic        done32, done3;
  logic        pass32, pass3;
  logic [15:0] err32, err3;
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
  logic        fv32, fv3;
  logic [15:0] fi32, fi3;
  logic [3:0]  fd32, fd3;
`endif

  int          mode32;
  int          mode3;
  logic [3:0]  force32;
  logic [3:0]  force3;

  int checks;
  int errors;

  logic [3:0] vec_exp [8];

  logic        obs_busy, obs_done, obs_pass;
  logic [3:0]  obs_cin;
  logic [15:0] obs_err;

  assign start32 = st & ~sel;
  assign start3  = st & sel;

  assign obs_busy = sel ? busy3 : busy32;
  assign obs_done = sel ? done3 : done32;
  assign obs_pass = sel ? pass3 : pass32;
  assign obs_cin  = sel ? cin3  : cin32;
  assign obs_err  = sel ? err3  : err32;

  chain_vector_sequencer #(
    .IO_PAIRS (2),
    .DEPTH    (32),
    .LFSR_SEED(16'hACE1)
  ) u_dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start32),
    .n_vectors    (n_vec),
    .settle_cycles(settle),
    .chain_in     (cin32),
    .chain_out    (out32),
    .busy         (busy32),
    .done         (done32),
    .pass         (pass32),
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
    .fail_valid   (fv32),
    .fail_idx     (fi32),
    .fail_data    (fd32),
`endif
    .err_count    (err32)
  );

  chain_vector_sequencer #(
    .IO_PAIRS (2),
    .DEPTH    (3),
    .LFSR_SEED(16'hACE1)
  ) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start3),
    .n_vectors    (n_vec),
    .settle_cycles(settle),
    .chain_in     (cin3),
    .chain_out    (out3),
    .busy         (busy3),
    .done         (done3),
    .pass         (pass3),
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
    .fail_valid   (fv3),
    .fail_idx     (fi3),
    .fail_data    (fd3),
`endif
    .err_count    (err3)
  );

  // Stage-by-stage chain: b ^= a, then a = ~a
  function automatic logic [3:0] chain_model(
    input logic [3:0] v,
    input int         depth
  );
    logic [3:0] s;
    s = v;
    for (int d = 0; d < depth; d++) begin
      for (int j = 0; j < 2; j++) begin
        s[2*j+1] = s[2*j+1] ^ s[2*j];
        s[2*j]   = ~s[2*j];
      end
    end
    return s;
  endfunction

  always_comb begin
    out32 = chain_model(cin32, 32);
    if (mode32 == 1) out32 = force32;
    else if (mode32 == 2 && cin32 == 4'h7) out32 = 4'hA;
  end

  always_comb begin
    out3 = chain_model(cin3, 3);
    if (mode3 == 1) out3 = force3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(
    input int    n,
    input int    s,
    input int    exp_done,
    input bit    chk_vec,
    input bit    spam,
    input string tag
  );
    int cyc;
    int k;
    bit got;
    n_vec  = 16'(n);
    settle = 8'(s);
    st     = 1'b1;
    cyc    = 0;
    got    = 1'b0;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!spam) st = 1'b0;
      if (cyc == 1) chk({tag, "_busy"}, obs_busy, 1);
      if (chk_vec && cyc >= 2 && ((cyc - 2) % (s + 2)) == 0) begin
        k = (cyc - 2) / (s + 2);
        if (k < n && k < 8)
          chk($sformatf("%s_vec%0d", tag, k), obs_cin, vec_exp[k]);
      end
      if (obs_done) got = 1'b1;
    end
    st = 1'b0;
    chk({tag, "_done_cyc"}, cyc, exp_done);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, obs_done, 0);
    chk({tag, "_idle"}, obs_busy, 0);
  endtask

  initial begin
    int seen;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    st      = 1'b0;
    sel     = 1'b0;
    n_vec   = '0;
    settle  = '0;
    mode32  = 0;
    mode3   = 0;
    force32 = '0;
    force3  = '0;
    vec_exp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h9, 4'h2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cin", cin32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_pass", pass32, 0);
    chk("rst_err", err32, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", busy32, 0);
    chk("post_rst_cin", cin32, 0);
    chk("post_rst_pass", pass32, 0);

    // Depth 32, identity chain
    run(4, 2, 17, 1'b1, 1'b0, "d32_n4");
    chk("d32_n4_pass", pass32, 1);
    chk("d32_n4_err", err32, 0);

    // Depth 3 against hand-computed golden for vector 4'h1 -> 4'hC
    sel    = 1'b1;
    mode3  = 1;
    force3 = 4'b1100;
    run(1, 2, 5, 1'b1, 1'b0, "d3_good");
    chk("d3_good_pass", pass3, 1);
    chk("d3_good_err", err3, 0);
    force3 = 4'b0011;
    run(1, 2, 5, 1'b0, 1'b0, "d3_bad");
    chk("d3_bad_pass", pass3, 0);
    chk("d3_bad_err", err3, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("d3_bad_pass_hold", pass3, 0);
    chk("d3_bad_err_hold", err3, 1);
    force3 = 4'b0001;
    run(1, 0, 3, 1'b0, 1'b0, "d3_ident");
    chk("d3_ident_err", err3, 1);
    mode3 = 0;
    run(4, 1, 13, 1'b1, 1'b0, "d3_model");
    chk("d3_model_pass", pass3, 1);
    chk("d3_model_err", err3, 0);
    sel = 1'b0;

    // Stuck-at-zero output, then a single corrupted vector
    mode32  = 1;
    force32 = 4'h0;
    run(8, 1, 25, 1'b1, 1'b0, "d32_stuck");
    chk("d32_stuck_pass", pass32, 0);
    chk("d32_stuck_err", err32, 8);
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
    chk("ff_stuck_valid", fv32, 1);
    chk("ff_stuck_idx", fi32, 0);
    chk("ff_stuck_data", fd32, 0);
`endif
    mode32 = 2;
    run(8, 0, 17, 1'b1, 1'b0, "d32_one");
    chk("d32_one_err", err32, 1);
    chk("d32_one_pass", pass32, 0);
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
    chk("ff_one_valid", fv32, 1);
    chk("ff_one_idx", fi32, 2);
    chk("ff_one_data", fd32, 4'hA);
`endif
    mode32 = 0;

    // Empty run and zero settle
    run(0, 3, 1, 1'b0, 1'b0, "d32_n0");
    chk("d32_n0_pass", pass32, 1);
    chk("d32_n0_err", err32, 0);
`ifdef CHAIN_SEQ_FIRST_FAIL_EN
    chk("ff_n0_valid", fv32, 0);
`endif
    run(3, 0, 7, 1'b1, 1'b0, "d32_s0");
    chk("d32_s0_pass", pass32, 1);

    // start held high throughout a run
    run(4, 2, 17, 1'b1, 1'b1, "d32_spam");
    chk("d32_spam_err", err32, 0);
    chk("d32_spam_pass", pass32, 1);

    // Reset during SETTLE of the second vector
    n_vec  = 16'd4;
    settle = 8'd2;
    st     = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_pre_cin", cin32, 4'h3);
    chk("abort_pre_busy", busy32, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cin", cin32, 0);
    chk("abort_busy", busy32, 0);
    chk("abort_done", done32, 0);
    chk("abort_pass", pass32, 0);
    chk("abort_err", err32, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done32 || busy32) seen++;
    end
    chk("abort_no_done", seen, 0);
    run(2, 2, 9, 1'b1, 1'b0, "replay");
    chk("replay_pass", pass32, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
